mem_access_ctrl: RTL and testbench

- Sequences the EN/RW/MFC handshake of the 16-bit asynchronous-handshake memory (MAR/MDR interface, MFC completion flag).
- Shares that memory between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the CPU control unit and the memory. Converts clocked req/ack transactions into the memory's EN-edge-triggered protocol.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 50 +++++
 rtl/mem_access_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    STROBE   = 3'd2,
    WAIT_MFC = 3'd3,
    RESP     = 3'd4
  } state_e;

  // Memory RW pin encoding.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Identifies which requester owns the current access.
  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Fetch/data arbiter: data has priority, but fetch is forced once it has
// watched STARVE_MAX consecutive data grants go by.
module mem_arb_pick
  import mem_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic f_req_i,
  input  logic d_req_i,
  input  logic gnt_i,
  output gnt_e winner_o
);

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             force_fetch;

  assign force_fetch = (starve_q == CNT_W'(STARVE_MAX));

  // Winner select: data unless only fetch is asking or fetch has starved.
  always_comb begin
    winner_o = GNT_FETCH;
    if (d_req_i && !(f_req_i && force_fetch)) begin
      winner_o = GNT_DATA;
    end
  end

  // Starvation count: data grants seen while fetch keeps waiting.
  always_comb begin
    starve_d = starve_q;
    if (!f_req_i) begin
      starve_d = '0;
    end else if (gnt_i) begin
      starve_d = (winner_o == GNT_DATA) ? starve_q + CNT_W'(1) : '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns clocked req/ack transactions from the
// fetch and data ports into the EN/RW/MFC handshake of the asynchronous
// memory. Optional macro MEM_TIMEOUT_EN bounds the wait for MFC and reports
// an abandoned access through err.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int STARVE_MAX  = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic              EN,
  output logic              RW,
  output logic [ADDR_W-1:0] MAR_to_MEM,
  output logic [DATA_W-1:0] MDR_to_MEM,
  input  logic [DATA_W-1:0] MEM_to_MDR,
  input  logic              MFC
);

  if (TIMEOUT_CYC < 2 || STARVE_MAX < 1) begin : g_param_check
    $error("mem_access_ctrl: TIMEOUT_CYC must be >= 2 and STARVE_MAX >= 1");
  end

  state_e            state_q, state_d;
  gnt_e              sel_q;
  gnt_e              winner;
  logic              grant;
  logic              timeout;
  logic              rw_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;
  logic [DATA_W-1:0] rd_word;

  // A stale MFC from an earlier (possibly abandoned) access blocks issue.
  assign grant = (state_q == IDLE) && (f_req || d_req) && !MFC;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .f_req_i  (f_req),
    .d_req_i  (d_req),
    .gnt_i    (grant),
    .winner_o (winner)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q;

  // Counts cycles since STROBE entry so the ack lands TIMEOUT_CYC cycles
  // after STROBE when MFC never arrives.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == SETUP) begin
      to_cnt_d = '0;
    end else if (state_q == STROBE || (state_q == WAIT_MFC && !MFC)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  assign timeout = (state_q == WAIT_MFC) && !MFC &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Timeout counter and error flag; err_q is only ever high during RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= timeout;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state logic for the handshake sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (grant) state_d = SETUP;
      SETUP:    state_d = STROBE;
      STROBE:   state_d = WAIT_MFC;
      WAIT_MFC: if (MFC || timeout) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register; reset abandons any access and drops EN at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A timed-out read returns zero instead of whatever the bus holds.
  assign rd_word = MFC ? MEM_to_MDR : '0;

  // Access registers: winner's request latched at grant and held through
  // RESP; read data captured into the owning port's rdata on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= GNT_FETCH;
      mar_q     <= '0;
      mdr_q     <= '0;
      rw_q      <= RW_WRITE;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant) begin
        sel_q <= winner;
        if (winner == GNT_DATA) begin
          mar_q <= d_addr;
          mdr_q <= d_wdata;
          rw_q  <= d_rw;
        end else begin
          mar_q <= f_addr;
          rw_q  <= RW_READ;
        end
      end
      if (state_q == WAIT_MFC && (MFC || timeout) && rw_q == RW_READ) begin
        if (sel_q == GNT_FETCH) begin
          f_rdata_q <= rd_word;
        end else begin
          d_rdata_q <= rd_word;
        end
      end
    end
  end

  assign EN         = (state_q == STROBE) || (state_q == WAIT_MFC);
  assign busy       = (state_q != IDLE);
  assign f_ack      = (state_q == RESP) && (sel_q == GNT_FETCH);
  assign d_ack      = (state_q == RESP) && (sel_q == GNT_DATA);
  assign RW         = rw_q;
  assign MAR_to_MEM = mar_q;
  assign MDR_to_MEM = mdr_q;
  assign f_rdata    = f_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: behavioural EN-edge memory, directed
// stimulus, and an ack-driven scoreboard monitor.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_rw;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        f_ack, d_ack, err, busy, EN, RW;
  logic [15:0] f_rdata, d_rdata, MAR_to_MEM, MDR_to_MEM;
  logic [15:0] MEM_to_MDR = 16'h0000;
  logic        MFC = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W(16), .DATA_W(16), .STARVE_MAX(3), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .busy(busy),
    .EN(EN), .RW(RW), .MAR_to_MEM(MAR_to_MEM), .MDR_to_MEM(MDR_to_MEM),
    .MEM_to_MDR(MEM_to_MDR), .MFC(MFC)
  );

  // ---------------- memory model (acts mid-cycle, on negedge) -------------
  logic [15:0] mem [0:511];
  bit          mem_active = 1'b0;
  int          stick_cnt  = 0;
  int          mfc_stick  = 0;   // extra cycles MFC lingers after EN falls
  bit          mfc_block  = 1'b0; // memory never completes
  int          en_rises   = 0;

  always @(negedge clk) begin
    if (EN) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        en_rises++;
        if (RW) MEM_to_MDR = mem[MAR_to_MEM[8:0]];
        else    mem[MAR_to_MEM[8:0]] = MDR_to_MEM;
        stick_cnt = mfc_stick;
      end
      if (!mfc_block) MFC = 1'b1;
    end else begin
      mem_active = 1'b0;
      if (MFC) begin
        if (stick_cnt > 0) stick_cnt--;
        else               MFC = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ---------------------------------------------
  typedef struct packed {
    logic        port;   // 1 = data port, 0 = fetch port
    logic [15:0] data;   // required rdata of that port at its ack
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   acks_seen = 0;
  logic [15:0] model_f = 16'h0000;
  logic [15:0] model_d = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation for every ack the DUT presents.
  always @(negedge clk) begin
    if (f_ack || d_ack) begin
      acks_seen++;
      chk("ack_exclusive", {31'd0, f_ack & d_ack}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual f_ack=%0b d_ack=%0b required none", f_ack, d_ack);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_port", {31'd0, d_ack}, {31'd0, mon_e.port});
        chk("ack_rdata", {16'd0, (mon_e.port ? d_rdata : f_rdata)}, {16'd0, mon_e.data});
        chk("ack_err", {31'd0, err}, {31'd0, mon_e.err});
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit port, input int limit, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      cyc = i + 1;
      if (port ? d_ack : f_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout port=%0d actual none required ack within %0d cycles", port, limit);
    end
  endtask

  task automatic do_fetch(input logic [15:0] addr, input logic [15:0] exp_data, output int cyc);
    bit ok;
    tick();
    model_f = exp_data;
    exp_q.push_back('{port: 1'b0, data: exp_data, err: 1'b0});
    f_addr = addr;
    f_req  = 1'b1;
    wait_ack(1'b0, 20, ok, cyc);
    tick();
    f_req = 1'b0;
  endtask

  task automatic do_data(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rd);
    bit ok;
    int cyc;
    tick();
    if (rw) model_d = exp_rd;
    exp_q.push_back('{port: 1'b1, data: model_d, err: 1'b0});
    d_rw    = rw;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    wait_ack(1'b1, 20, ok, cyc);
    tick();
    d_req = 1'b0;
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    int  cyc;
    int  n;
    int  n0;
    bit  hit;
    bit  bad;
    bit  ok;

    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[1] = 16'hF0AF;
    mem[2] = 16'h0042;

    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; d_rw = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    chk("rst_ctrl", {26'd0, f_ack, d_ack, err, busy, EN, RW}, 32'd0);
    chk("rst_mar", {16'd0, MAR_to_MEM}, 32'd0);
    chk("rst_mdr", {16'd0, MDR_to_MEM}, 32'd0);
    chk("rst_rdata", {f_rdata, d_rdata}, 32'd0);
    reset = 1'b0;
    tick();

    // Single fetch: latency and one EN edge.
    en_rises = 0;
    do_fetch(16'h0001, 16'hF0AF, cyc);
    chk("fetch_latency", cyc, 32'd4);
    chk("fetch_en_rises", en_rises, 32'd1);

    // Data write then reads.
    do_data(1'b0, 16'h0100, 16'hBEEF, 16'h0000);
    do_data(1'b1, 16'h0100, 16'h0000, 16'hBEEF);
    do_data(1'b1, 16'h0002, 16'h0000, 16'h0042);
    chk("f_rdata_kept", {16'd0, f_rdata}, {16'd0, model_f});

    // Both requesters held: D,D,D,F,D,D,D,F.
    tick();
    f_addr = 16'h0001; d_addr = 16'h0002; d_rw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 3 || k == 7) exp_q.push_back('{port: 1'b0, data: 16'hF0AF, err: 1'b0});
      else                  exp_q.push_back('{port: 1'b1, data: 16'h0042, err: 1'b0});
    end
    f_req = 1'b1; d_req = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (f_ack || d_ack) n++;
      if (n == 8) break;
    end
    f_req = 1'b0; d_req = 1'b0;
    chk("burst_acks", n, 32'd8);
    tick(); tick();

    // Reset during WAIT_MFC with MFC high, MFC lingering afterwards.
    mfc_stick = 4;
    f_addr = 16'h0001;
    f_req  = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (EN && MFC) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_wait_mfc", {31'd0, hit}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_f = 16'h0000; model_d = 16'h0000;
    chk("rst_drops_en", {30'd0, EN, busy}, 32'd0);
    chk("rst_clears_rdata", {f_rdata, d_rdata}, 32'd0);
    bad = 1'b0;
    n = 0;
    while (MFC && n < 30) begin
      if (EN || busy) bad = 1'b1;
      tick();
      n++;
    end
    chk("no_issue_on_stale_mfc", {31'd0, bad}, 32'd0);
    chk("stale_mfc_fell", {31'd0, MFC}, 32'd0);
    mfc_stick = 0;
    model_f = 16'hF0AF;
    exp_q.push_back('{port: 1'b0, data: 16'hF0AF, err: 1'b0});
    wait_ack(1'b0, 20, ok, cyc);
    tick();
    f_req = 1'b0;
    tick();

    // Memory that never completes.
    mfc_block = 1'b1;
    d_addr = 16'h0002; d_rw = 1'b1;
`ifdef MEM_TIMEOUT_EN
    model_d = 16'h0000;
    exp_q.push_back('{port: 1'b1, data: 16'h0000, err: 1'b1});
    d_req = 1'b1;
    wait_ack(1'b1, 100, ok, cyc);
    chk("timeout_latency", cyc, 32'd66);
    tick();
    d_req = 1'b0;
    mfc_block = 1'b0;
`else
    d_req = 1'b1;
    n0 = acks_seen;
    repeat (100) tick();
    chk("stuck_no_ack", acks_seen, n0);
    chk("stuck_busy_en", {30'd0, busy, EN}, 32'd3);
    d_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mfc_block = 1'b0;
    model_f = 16'h0000; model_d = 16'h0000;
    chk("recover_idle", {31'd0, busy}, 32'd0);
`endif
    tick();

    // Recovery access.
    do_data(1'b1, 16'h0100, 16'h0000, 16'hBEEF);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=time_limit required=finish");
    $fatal(1, "watchdog");
  end

endmodule
